// File: rtl/calc_button_conditioner.sv
// rtl/calc_button_conditioner.sv - per-button synchronizer, debounce, edge pulses and auto-repeat
module calc_button_conditioner #(
  parameter int                     NUM_BUTTONS     = 5,
  parameter int                     DEBOUNCE_CYCLES = 1000000,
  parameter logic [NUM_BUTTONS-1:0] REPEAT_MASK     = 5'b00011,
  parameter int                     REPEAT_DELAY    = 50000000,
  parameter int                     REPEAT_PERIOD   = 10000000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_BUTTONS-1:0] btn_raw,
  output logic [NUM_BUTTONS-1:0] btn_level,
  output logic [NUM_BUTTONS-1:0] btn_press,
  output logic [NUM_BUTTONS-1:0] btn_release,
  output logic                   any_press
);

  localparam int DB_W = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam int RP_W = $clog2(REPEAT_DELAY) + 1;

  localparam logic [DB_W-1:0] DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [RP_W-1:0] RP_FIRE   = RP_W'(REPEAT_DELAY);
  localparam logic [RP_W-1:0] RP_RELOAD = RP_W'(REPEAT_DELAY - REPEAT_PERIOD);

  logic [NUM_BUTTONS-1:0] sync1;
  logic [NUM_BUTTONS-1:0] sync2;
  logic [NUM_BUTTONS-1:0] press_next;
  logic [NUM_BUTTONS-1:0] release_next;

  // Two-flop synchronizer bringing the asynchronous pins into the clk domain
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= btn_raw;
      sync2 <= sync1;
    end
  end

  for (genvar i = 0; i < NUM_BUTTONS; i++) begin : g_ch
    logic [DB_W-1:0] db_cnt;
    logic            db_done;
    logic            rise;
    logic            fall;
    logic            rep_fire;

    // A level change is accepted once the differing sample has been stable
    // for the full debounce window; any return to the current level restarts it.
    assign db_done = (sync2[i] != btn_level[i]) && (db_cnt == DB_LAST);
    assign rise    = db_done && !btn_level[i];
    assign fall    = db_done &&  btn_level[i];

    // Debounce counter and the accepted level for this channel
    always_ff @(posedge clk) begin
      if (rst) begin
        db_cnt       <= '0;
        btn_level[i] <= 1'b0;
      end else if (sync2[i] == btn_level[i]) begin
        db_cnt <= '0;
      end else if (db_done) begin
        db_cnt       <= '0;
        btn_level[i] <= ~btn_level[i];
      end else begin
        db_cnt <= db_cnt + DB_W'(1);
      end
    end

    if (REPEAT_MASK[i]) begin : g_rep
      logic [RP_W-1:0] rp_cnt;
      logic [RP_W-1:0] rp_next;

      assign rp_next = rp_cnt + RP_W'(1);
      // The falling-edge cycle is excluded so a release never carries a repeat with it
      assign rep_fire = btn_level[i] && !fall && (rp_next == RP_FIRE);

      // Hold-time counter: first pulse after REPEAT_DELAY, then every REPEAT_PERIOD
      always_ff @(posedge clk) begin
        if (rst || !btn_level[i] || fall) begin
          rp_cnt <= '0;
        end else if (rep_fire) begin
          rp_cnt <= RP_RELOAD;
        end else begin
          rp_cnt <= rp_next;
        end
      end
    end else begin : g_norep
      assign rep_fire = 1'b0;
    end

    assign press_next[i]   = rise | rep_fire;
    assign release_next[i] = fall;
  end

  // Registered pulse outputs, aligned with the level update
  always_ff @(posedge clk) begin
    if (rst) begin
      btn_press   <= '0;
      btn_release <= '0;
      any_press   <= 1'b0;
    end else begin
      btn_press   <= press_next;
      btn_release <= release_next;
      any_press   <= |press_next;
    end
  end

endmodule

// File: tb/tb_calc_button_conditioner.sv
// tb/tb_calc_button_conditioner.sv - directed bench for calc_button_conditioner
module tb_calc_button_conditioner;

  logic       clk;
  logic       rst;
  logic [4:0] btn_raw;
  logic [4:0] btn_level;
  logic [4:0] btn_press;
  logic [4:0] btn_release;
  logic       any_press;

  int vectors;
  int miscompares;
  int press_cnt [5];
  int rel_cnt   [5];
  int any_cnt;
  int both_cnt;

  calc_button_conditioner #(
    .NUM_BUTTONS    (5),
    .DEBOUNCE_CYCLES(4),
    .REPEAT_MASK    (5'b00011),
    .REPEAT_DELAY   (20),
    .REPEAT_PERIOD  (8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .btn_raw    (btn_raw),
    .btn_level  (btn_level),
    .btn_press  (btn_press),
    .btn_release(btn_release),
    .any_press  (any_press)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    for (int b = 0; b < 5; b++) begin
      press_cnt[b] += int'(btn_press[b]);
      rel_cnt[b]   += int'(btn_release[b]);
    end
    any_cnt  += int'(any_press);
    both_cnt += int'(|(btn_press & btn_release));
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic clear_counts();
    for (int b = 0; b < 5; b++) begin
      press_cnt[b] = 0;
      rel_cnt[b]   = 0;
    end
    any_cnt = 0;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    both_cnt    = 0;
    clear_counts();
    rst     = 1'b1;
    btn_raw = '0;
    run(3);
    chk("reset_level",   32'(btn_level),   32'h0);
    chk("reset_press",   32'(btn_press),   32'h0);
    chk("reset_release", 32'(btn_release), 32'h0);
    chk("reset_any",     32'(any_press),   32'h0);
    rst = 1'b0;
    run(3);
    chk("idle_level", 32'(btn_level), 32'h0);

    // Clean press on C: raw first sampled at E0, level rises at E5
    clear_counts();
    btn_raw = 5'b00100;
    run(5);
    chk("clean_level_e4", 32'(btn_level), 32'h0);
    chk("clean_press_e4", 32'(btn_press), 32'h0);
    step();
    chk("clean_level_e5", 32'(btn_level), 32'h04);
    chk("clean_press_e5", 32'(btn_press), 32'h04);
    chk("clean_any_e5",   32'(any_press), 32'h1);
    chk("clean_rel_e5",   32'(btn_release), 32'h0);
    step();
    chk("clean_press_e6", 32'(btn_press), 32'h0);
    chk("clean_any_e6",   32'(any_press), 32'h0);
    run(23);
    chk("clean_no_repeat", 32'(press_cnt[2]), 32'd1);
    btn_raw = 5'b00000;
    run(10);
    chk("clean_rel_count", 32'(rel_cnt[2]), 32'd1);
    chk("clean_level_off", 32'(btn_level), 32'h0);

    // Bounce on R: 1,0,1,0 then held low
    clear_counts();
    btn_raw = 5'b10000; step();
    btn_raw = 5'b00000; step();
    btn_raw = 5'b10000; step();
    btn_raw = 5'b00000;
    run(10);
    chk("bounce_level", 32'(btn_level), 32'h0);
    chk("bounce_press", 32'(press_cnt[4]), 32'd0);
    chk("bounce_rel",   32'(rel_cnt[4]), 32'd0);

    // Glitch on L: three high samples are rejected
    clear_counts();
    btn_raw = 5'b01000;
    run(3);
    btn_raw = 5'b00000;
    run(10);
    chk("glitch3_press", 32'(press_cnt[3]), 32'd0);
    chk("glitch3_level", 32'(btn_level), 32'h0);

    // L held: accepted at E5, released after 10 cycles, release 5 edges after raw falls
    clear_counts();
    btn_raw = 5'b01000;
    run(6);
    chk("hold_l_press_e5", 32'(btn_press), 32'h08);
    run(4);
    btn_raw = 5'b00000;
    run(5);
    chk("rel_l_f4", 32'(btn_release), 32'h0);
    step();
    chk("rel_l_f5",     32'(btn_release), 32'h08);
    chk("rel_l_level",  32'(btn_level), 32'h0);
    step();
    chk("rel_l_f6",     32'(btn_release), 32'h0);
    chk("hold_l_press_total", 32'(press_cnt[3]), 32'd1);
    chk("hold_l_rel_total",   32'(rel_cnt[3]), 32'd1);

    // Auto-repeat on U: pulses at +0, +20, +28, +36, +44, +52; release at +60 with no repeat
    clear_counts();
    btn_raw = 5'b00001;
    run(6);
    chk("rep_first", 32'(btn_press), 32'h01);
    run(19);
    chk("rep_gap_count", 32'(press_cnt[0]), 32'd1);
    step();
    chk("rep_plus20", 32'(btn_press), 32'h01);
    run(34);
    chk("rep_mid_count", 32'(press_cnt[0]), 32'd6);
    btn_raw = 5'b00000;
    run(6);
    chk("rep_rel_edge_press", 32'(btn_press), 32'h0);
    chk("rep_rel_edge_rel",   32'(btn_release), 32'h01);
    run(4);
    chk("rep_total", 32'(press_cnt[0]), 32'd6);

    // Same hold on C: unmasked, single pulse
    clear_counts();
    btn_raw = 5'b00100;
    run(60);
    btn_raw = 5'b00000;
    run(10);
    chk("norep_total", 32'(press_cnt[2]), 32'd1);
    chk("norep_rel",   32'(rel_cnt[2]), 32'd1);

    // Simultaneous U and D
    clear_counts();
    btn_raw = 5'b00011;
    run(6);
    chk("simul_press", 32'(btn_press), 32'h03);
    chk("simul_any",   32'(any_press), 32'h1);
    btn_raw = 5'b00000;
    step();
    chk("simul_press_next", 32'(btn_press), 32'h0);
    chk("simul_any_next",   32'(any_press), 32'h0);
    run(10);
    chk("simul_any_count", 32'(any_cnt), 32'd1);
    chk("simul_rel",       32'(btn_release | btn_level), 32'h0);

    // Reset mid-hold on C: no release, one re-press visible in the 7th cycle after reset
    btn_raw = 5'b00100;
    run(8);
    chk("rst_pre_level", 32'(btn_level), 32'h04);
    clear_counts();
    rst = 1'b1;
    step();
    chk("rst_level_clear", 32'(btn_level), 32'h0);
    chk("rst_rel_none",    32'(btn_release), 32'h0);
    rst = 1'b0;
    clear_counts();
    run(5);
    chk("rst_f5_press", 32'(press_cnt[2]), 32'd0);
    step();
    chk("rst_f6_press", 32'(btn_press), 32'h04);
    chk("rst_f6_level", 32'(btn_level), 32'h04);
    run(10);
    chk("rst_press_once", 32'(press_cnt[2]), 32'd1);
    chk("rst_rel_total",  32'(rel_cnt[2]), 32'd0);
    btn_raw = 5'b00000;
    run(10);

    chk("press_release_exclusive", 32'(both_cnt), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
